// File: rtl/beta_pkg.sv
// beta_pkg: shared definitions for the Beta fetch front end and control decoder.
//   - PCSEL encodings consumed by the next-PC logic
//   - default reset / illegal-op / exception vectors
//   - fetch FSM state type
//   - instruction word field bit positions
package beta_pkg;

  localparam logic [2:0] PCSEL_INC   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JT    = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;
  localparam logic [2:0] PCSEL_XADR  = 3'd4;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_ILLOP_VECTOR = 32'h0000_0004;
  localparam logic [31:0] DEF_XADR_VECTOR  = 32'h0000_0008;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_ACK = 2'd1,
    HOLD     = 2'd2
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB  = 31;
  localparam int unsigned OPCODE_LSB  = 26;
  localparam int unsigned RC_MSB      = 25;
  localparam int unsigned RC_LSB      = 21;
  localparam int unsigned RA_MSB      = 20;
  localparam int unsigned RA_LSB      = 16;
  localparam int unsigned RB_MSB      = 15;
  localparam int unsigned RB_LSB      = 11;
  localparam int unsigned LITERAL_MSB = 15;
  localparam int unsigned LITERAL_LSB = 0;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC selection.
//   pc_i       current instruction address
//   pcsel_i    0 PC+4, 1 branch, 2 jump target, 3 ILLOP, 4 XADR, 5-7 ILLOP
//   jt_i       register jump target
//   literal_i  16-bit branch displacement in words
//   pc_next_o  selected address, always word aligned
module pc_next_mux import beta_pkg::*; #(
  parameter logic [31:0] ILLOP_VECTOR = DEF_ILLOP_VECTOR,
  parameter logic [31:0] XADR_VECTOR  = DEF_XADR_VECTOR
) (
  input  logic [31:0] pc_i,
  input  logic [2:0]  pcsel_i,
  input  logic [31:0] jt_i,
  input  logic [15:0] literal_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] pc_inc;
  logic [31:0] br_off;

  assign pc_inc = pc_i + 32'd4;
  assign br_off = {{14{literal_i[15]}}, literal_i, 2'b00};

  always_comb begin
    pc_next_o = ILLOP_VECTOR;
    case (pcsel_i)
      PCSEL_INC:   pc_next_o = pc_inc;
      PCSEL_BR:    pc_next_o = pc_inc + br_off;
      PCSEL_JT:    pc_next_o = jt_i;
      PCSEL_ILLOP: pc_next_o = ILLOP_VECTOR;
      PCSEL_XADR:  pc_next_o = XADR_VECTOR;
      default:     pc_next_o = ILLOP_VECTOR;
    endcase
    // Alignment is enforced once here for every source, JT included.
    pc_next_o[1:0] = 2'b00;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, single-outstanding instruction fetch over a
// req/ack handshake, and instruction register driving decoded fields.
//   CLK, RESET           clock, synchronous active-high reset
//   PCSEL, JT            next-PC select and jump target, sampled on ADVANCE
//   ADVANCE              datapath retires the current instruction
//   IMEM_REQ/ADDR        fetch request and word address
//   IMEM_ACK/RDATA       fetch completion and instruction word
//   INSTR_VALID          decoded fields below are valid
//   OPCODE,RC,RA,RB,LITERAL  fields of the instruction register
//   PC, PC_PLUS4         current instruction address and its successor
module instr_fetch_unit import beta_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] ILLOP_VECTOR = DEF_ILLOP_VECTOR,
  parameter logic [31:0] XADR_VECTOR  = DEF_XADR_VECTOR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  PCSEL,
  input  logic [31:0] JT,
  input  logic        ADVANCE,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic        INSTR_VALID,
  output logic [5:0]  OPCODE,
  output logic [4:0]  RC,
  output logic [4:0]  RA,
  output logic [4:0]  RB,
  output logic [15:0] LITERAL,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4
);

  fetch_state_e state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  pc_next;
  logic         capture;

  pc_next_mux #(
    .ILLOP_VECTOR (ILLOP_VECTOR),
    .XADR_VECTOR  (XADR_VECTOR)
  ) u_pc_next_mux (
    .pc_i      (pc_q),
    .pcsel_i   (PCSEL),
    .jt_i      (JT),
    .literal_i (ir_q[LITERAL_MSB:LITERAL_LSB]),
    .pc_next_o (pc_next)
  );

  // IMEM_REQ is registered, so an ACK is only honoured once the request is
  // visible; this drops stale ACKs in the idle cycle that follows reset.
  assign capture = req_q & IMEM_ACK;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        req_d   = 1'b1;
        state_d = WAIT_ACK;
        if (capture) begin
          ir_d    = IMEM_RDATA;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      WAIT_ACK: begin
        req_d = 1'b1;
        if (capture) begin
          ir_d    = IMEM_RDATA;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        req_d = 1'b0;
        if (ADVANCE) begin
          pc_d    = pc_next;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = pc_q;
  assign INSTR_VALID = (state_q == HOLD);
  assign OPCODE      = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign RC          = ir_q[RC_MSB:RC_LSB];
  assign RA          = ir_q[RA_MSB:RA_LSB];
  assign RB          = ir_q[RB_MSB:RB_LSB];
  assign LITERAL     = ir_q[LITERAL_MSB:LITERAL_LSB];
  assign PC          = pc_q;
  assign PC_PLUS4    = pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by random
// fetch/advance traffic, with expected fetch addresses and instructions
// queued by the driver and checked by an independent monitor.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  PCSEL;
  logic [31:0] JT;
  logic        ADVANCE;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic        INSTR_VALID;
  logic [5:0]  OPCODE;
  logic [4:0]  RC;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [15:0] LITERAL;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .ILLOP_VECTOR (32'h0000_0004),
    .XADR_VECTOR  (32'h0000_0008)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PCSEL       (PCSEL),
    .JT          (JT),
    .ADVANCE     (ADVANCE),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_ACK    (IMEM_ACK),
    .IMEM_RDATA  (IMEM_RDATA),
    .INSTR_VALID (INSTR_VALID),
    .OPCODE      (OPCODE),
    .RC          (RC),
    .RA          (RA),
    .RB          (RB),
    .LITERAL     (LITERAL),
    .PC          (PC),
    .PC_PLUS4    (PC_PLUS4)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } instr_t;

  logic [31:0] exp_addr_q[$];
  instr_t      exp_instr_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc;
  logic [31:0] model_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Architectural next-PC rule written as plain address arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [2:0] sel,
                                           input logic [31:0] jt, input logic [15:0] lit);
    int signed disp;
    disp = int'($signed(lit)) * 4;
    if (sel == 3'd0)      return pc + 32'd4;
    else if (sel == 3'd1) return pc + 32'd4 + 32'(disp);
    else if (sel == 3'd2) return jt - (jt % 32'd4);
    else if (sel == 3'd4) return 32'h0000_0008;
    else                  return 32'h0000_0004;
  endfunction

  // Monitor: pops an expected address on each new request and an expected
  // instruction each time INSTR_VALID rises.
  logic        mon_en = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_addr = '0;
  instr_t      mon_e;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (IMEM_REQ === 1'b1 && !prev_req) begin
        if (exp_addr_q.size() == 0) fail_now("unexpected_req");
        else chk("fetch_addr", IMEM_ADDR, exp_addr_q.pop_front());
        held_addr = IMEM_ADDR;
      end else if (IMEM_REQ === 1'b1 && prev_req) begin
        chk("addr_stable", IMEM_ADDR, held_addr);
      end
      if (INSTR_VALID === 1'b1 && !prev_valid) begin
        if (exp_instr_q.size() == 0) fail_now("unexpected_valid");
        else begin
          mon_e = exp_instr_q.pop_front();
          chk("opcode",   32'(OPCODE),   32'(mon_e.ir[31:26]));
          chk("rc",       32'(RC),       32'(mon_e.ir[25:21]));
          chk("ra",       32'(RA),       32'(mon_e.ir[20:16]));
          chk("rb",       32'(RB),       32'(mon_e.ir[15:11]));
          chk("literal",  32'(LITERAL),  32'(mon_e.ir[15:0]));
          chk("pc",       PC,            mon_e.pc);
          chk("pc_plus4", PC_PLUS4,      mon_e.pc + 32'd4);
        end
      end
    end
    prev_req   = (IMEM_REQ === 1'b1);
    prev_valid = (INSTR_VALID === 1'b1);
  end

  // ACK is held high through reset and the first cycle after it; neither
  // may be captured.
  task automatic do_reset();
    RESET      = 1'b1;
    ADVANCE    = 1'b0;
    IMEM_ACK   = 1'b1;
    IMEM_RDATA = $urandom | 32'h8000_0000;
    exp_addr_q.delete();
    exp_instr_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    mon_en = 1'b1;
    chk("rst_valid",  32'(INSTR_VALID), 32'd0);
    chk("rst_req",    32'(IMEM_REQ),    32'd0);
    chk("rst_pc",     PC,               32'h0000_0000);
    chk("rst_pc4",    PC_PLUS4,         32'h0000_0004);
    chk("rst_opcode", 32'(OPCODE),      32'd0);
    model_pc = 32'h0000_0000;
    model_ir = '0;
    exp_addr_q.push_back(32'h0000_0000);
    RESET   = 1'b0;
    ADVANCE = 1'b1;
    PCSEL   = 3'd2;
    JT      = $urandom;
    @(negedge CLK);
    ADVANCE  = 1'b0;
    IMEM_ACK = 1'b0;
    chk("post_rst_valid",  32'(INSTR_VALID), 32'd0);
    chk("post_rst_opcode", 32'(OPCODE),      32'd0);
    chk("post_rst_pc",     PC,               32'h0000_0000);
  endtask

  task automatic fetch(input int unsigned delay, input logic [31:0] word);
    int unsigned n;
    instr_t e;
    n = 0;
    while (IMEM_REQ !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (IMEM_REQ !== 1'b1) begin
      fail_now("req_timeout");
      return;
    end
    for (int unsigned i = 0; i < delay; i++) begin
      IMEM_ACK   = 1'b0;
      IMEM_RDATA = $urandom;
      ADVANCE    = 1'($urandom_range(0, 1));
      PCSEL      = 3'($urandom);
      JT         = $urandom;
      @(negedge CLK);
      chk("wait_valid", 32'(INSTR_VALID), 32'd0);
    end
    ADVANCE    = 1'b0;
    IMEM_ACK   = 1'b1;
    IMEM_RDATA = word;
    e.ir = word;
    e.pc = model_pc;
    exp_instr_q.push_back(e);
    model_ir = word;
    @(negedge CLK);
    IMEM_ACK   = 1'b0;
    IMEM_RDATA = $urandom;
    chk("valid_latency", 32'(INSTR_VALID), 32'd1);
  endtask

  task automatic advance(input logic [2:0] sel, input logic [31:0] jt);
    int unsigned n;
    n = 0;
    while (INSTR_VALID !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (INSTR_VALID !== 1'b1) begin
      fail_now("valid_timeout");
      return;
    end
    PCSEL   = sel;
    JT      = jt;
    ADVANCE = 1'b1;
    model_pc = ref_next(model_pc, sel, jt, model_ir[15:0]);
    exp_addr_q.push_back(model_pc);
    @(negedge CLK);
    ADVANCE = 1'b0;
    PCSEL   = 3'($urandom);
    JT      = $urandom;
    chk("adv_pc",    PC,                 model_pc);
    chk("adv_pc4",   PC_PLUS4,           model_pc + 32'd4);
    chk("adv_valid", 32'(INSTR_VALID),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    RESET = 1'b1; PCSEL = '0; JT = '0; ADVANCE = 1'b0;
    IMEM_ACK = 1'b0; IMEM_RDATA = '0;

    do_reset();
    fetch(0, 32'hC020_0005);
    chk("tp_opcode",  32'(OPCODE),  32'h30);
    chk("tp_rc",      32'(RC),      32'd1);
    chk("tp_ra",      32'(RA),      32'd0);
    chk("tp_literal", 32'(LITERAL), 32'd5);

    // Branch backwards and forwards from 0x100.
    advance(3'd2, 32'h0000_0100);
    fetch(0, 32'h6C00_FFFE);
    advance(3'd1, $urandom);
    chk("br_neg", PC, 32'h0000_00FC);
    fetch(1, $urandom);
    advance(3'd2, 32'h0000_0100);
    fetch(0, 32'h6C00_0003);
    advance(3'd1, $urandom);
    chk("br_pos", PC, 32'h0000_0110);

    // Jump alignment and vector targets.
    fetch(2, $urandom);
    advance(3'd2, 32'h0000_2003);
    chk("jt_align", PC, 32'h0000_2000);
    fetch(0, $urandom);
    advance(3'd6, $urandom);
    chk("illop_6", PC, 32'h0000_0004);
    fetch(0, $urandom);
    advance(3'd4, $urandom);
    chk("xadr", PC, 32'h0000_0008);

    // Delayed ACK with changing RDATA; only the ACK-cycle word is captured.
    fetch(3, 32'hA5A5_1234);
    chk("late_ack_literal", 32'(LITERAL), 32'h1234);

    // Wrap at the top of the address space, then ignored ADVANCE while fetching.
    advance(3'd2, 32'hFFFF_FFFC);
    fetch(0, 32'h0000_0000);
    advance(3'd0, $urandom);
    chk("wrap", PC, 32'h0000_0000);
    fetch(4, $urandom);
    chk("ignored_adv_pc", PC, 32'h0000_0000);

    // Reset in the middle of a fetch with ACK during and after reset.
    advance(3'd0, $urandom);
    IMEM_ACK = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    do_reset();
    fetch(0, $urandom);

    for (int k = 0; k < 60; k++) begin
      advance(3'($urandom), $urandom);
      fetch($urandom_range(0, 4), $urandom);
    end

    @(negedge CLK);
    @(negedge CLK);
    chk("addr_queue_empty",  32'(exp_addr_q.size()),  32'd0);
    chk("instr_queue_empty", 32'(exp_instr_q.size()), 32'd0);
    chk("final_pc",          PC,                      model_pc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end: holds the program counter, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents the decoded fields to the rest of the core. It sits on the other side of the control decoder:
- it produces the `OPCODE` the decoder consumes;
- it consumes the `PCSEL` the decoder/datapath produces.

Next PC is selected from `PCSEL`, the register jump target and the branch literal when the datapath retires the current instruction.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, PC loaded on reset
- `ILLOP_VECTOR`, 32'h0000_0004, target for PCSEL=3 and illegal PCSEL codes
- `XADR_VECTOR`, 32'h0000_0008, target for PCSEL=4

Ports:
- `CLK`  in  1  clock; all state on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `PCSEL`  in  3  next-PC select, sampled on ADVANCE: 0 PC+4, 1 branch, 2 JT, 3 ILLOP, 4 XADR
- `JT`  in  32  jump target (Ra value), sampled on ADVANCE
- `ADVANCE`  in  1  datapath retires current instruction
- `IMEM_REQ`  out  1  fetch request
- `IMEM_ADDR`  out  32  fetch address, word aligned
- `IMEM_ACK`  in  1  memory returns data this cycle
- `IMEM_RDATA`  in  32  instruction word, valid with ACK
- `INSTR_VALID`  out  1  instruction fields below are valid
- `OPCODE`  out  6  IR[31:26]
- `RC`, `RA`, `RB`  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- `LITERAL`  out  16  IR[15:0]
- `PC`  out  32  address of current instruction
- `PC_PLUS4`  out  32  PC+4 (for link writes)

## Operation
- FSM states: FETCH, WAIT_ACK, HOLD.
- Reset:
  - state FETCH, PC=RESET_VECTOR, IR=0;
  - INSTR_VALID=0, IMEM_REQ=0.
  - Reset dominates all other inputs.
  - Reset mid-fetch abandons the request.
- FETCH: drive IMEM_REQ=1, IMEM_ADDR=PC, go WAIT_ACK. If IMEM_ACK is already high in this cycle, capture and go HOLD.
- WAIT_ACK: keep IMEM_REQ=1 and IMEM_ADDR stable until IMEM_ACK. On ACK, IR<=IMEM_RDATA and go HOLD.
- HOLD: INSTR_VALID=1 and the fields are stable. On ADVANCE:
  - PC<=next PC;
  - INSTR_VALID<=0;
  - go FETCH.
- Next PC (modulo 2^32, low two bits forced 0):
  - 0: PC+4
  - 1: PC+4+(sext(LITERAL)<<2)
  - 2: {JT[31:2],2'b00}
  - 3: ILLOP_VECTOR
  - 4: XADR_VECTOR
  - 5–7: ILLOP_VECTOR
- ADVANCE while INSTR_VALID=0 is ignored.
- IMEM_ACK while IMEM_REQ=0 is ignored, including a stale ACK after reset.
- Outputs are registered from IR/PC; OPCODE=0 whenever IR=0, including after reset. Opcode 0 decodes to all-inactive controls.

## Timing
- IMEM_REQ goes high the cycle after reset deasserts. It also goes high the cycle after an ADVANCE that is accepted.
- ACK in the same cycle as REQ rise is legal. INSTR_VALID then rises the next cycle, giving a minimum 2-cycle ADVANCE→INSTR_VALID latency.
- Each ACK wait cycle adds 1 cycle of latency. No timeout.
- PCSEL/JT/LITERAL are sampled only in the ADVANCE cycle; they may change freely at other times.
- PC and PC_PLUS4 update one cycle after ADVANCE and stay stable through fetch and HOLD.
- One outstanding request at most; no prefetch.

## Structure
- Shared package `beta_pkg`:
  - PCSEL encodings (PCSEL_INC, PCSEL_BR, PCSEL_JT, PCSEL_ILLOP, PCSEL_XADR);
  - default vector constants;
  - fetch FSM state enum;
  - instruction field bit positions.
- Sub-module `pc_next_mux`: purely combinational next-PC computation from PC, PCSEL, JT, LITERAL. Instantiated once and unit-tested separately.
- FSM, PC and IR registers live in `instr_fetch_unit`.

## Test plan
- Reset then ACK immediately, RDATA=32'hC020_0005:
  - IMEM_ADDR=0;
  - INSTR_VALID=1 two cycles after reset release;
  - OPCODE=6'h30, RC=1, RA=0, LITERAL=5.
- HOLD with PC=0x100, PCSEL=1, LITERAL=16'hFFFE, ADVANCE → next IMEM_ADDR=0x0FC. Repeat with LITERAL=16'h0003 → 0x110.
- PCSEL=2, JT=32'h0000_2003, ADVANCE → IMEM_ADDR=0x2000. PCSEL=6 → IMEM_ADDR=0x4. PCSEL=4 → 0x8.
- ACK delayed 3 cycles with RDATA changing before ACK → IMEM_ADDR stable; IR equals RDATA at the ACK cycle only.
- RESET asserted in WAIT_ACK, ACK arriving during reset and one cycle after:
  - no capture; INSTR_VALID=0;
  - refetch from 0.
- PC=32'hFFFF_FFFC, PCSEL=0 → wrap to 0. ADVANCE while INSTR_VALID=0 → no PC change, no extra request.
